lcd_write_arbiter: RTL
======================

// Module: lcd_write_arbiter
// PURPOSE
//  Shares the single lcd_write SPI serializer among several word sources: init sequencer, char renderer, fill/clear engine.
//  Sources raise a request; the arbiter grants one, issues one en_write, and waits for wr_done.
//  It then acks the source. Lock bursts keep command+parameter sequences contiguous.
//  Sits between the requesters and lcd_write; replaces the ad-hoc init/show_char data mux.
// PARAMETERS
//  NUM_REQ     3     number of requesters; index 0 = init sequencer (highest priority)
//  DATA_W      9     word width; bit 8 = D/C flag, bits 7:0 = payload
//  TIMEOUT_CYC 4096  max cycles from en_write to wr_done (used only with LCD_ARB_TIMEOUT_EN)
// PORTS
//  sys_clk_50MHz  in   1               single clock
//  sys_rst_n      in   1               asynchronous reset, active low
//  init_done      in   1               high once panel init has finished
//  req            in   NUM_REQ         per-source request, level; hold until ack
//  lock           in   NUM_REQ         per-source burst lock; sampled at ack time
//  req_data       in   NUM_REQ*DATA_W  per-source word; slice i = [i*DATA_W +: DATA_W]
//  grant          out  NUM_REQ         one-hot owner, or all zero
//  ack            out  NUM_REQ         1-cycle pulse: granted word fully written
//  data           out  DATA_W          word to lcd_write; stable from ISSUE until ack
//  en_write       out  1               1-cycle start pulse to lcd_write
//  wr_done        in   1               lcd_write completion pulse
//  busy           out  1               high in any state but IDLE
//  timeout_err    out  1               sticky error flag; constant 0 without LCD_ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset values:
//   - all outputs 0
//   - state IDLE
//   - round-robin pointer = 1
//  States are IDLE -> ISSUE -> WAIT -> ACK.
//  IDLE: when any request is eligible:
//   - pick the winner
//   - set grant one-hot
//   - register req_data slice into data
//   - go to ISSUE
//  ISSUE: en_write=1 for exactly one cycle, then go to WAIT.
//  WAIT: hold until wr_done=1, then go to ACK.
//  ACK: ack[owner]=1 for one cycle.
//   - if lock[owner] & req[owner]: re-register data and go to ISSUE; grant is kept, no re-arbitration.
//   - else: clear grant, pointer = owner+1 (mod NUM_REQ, skipping 0), go to IDLE.
//  Eligibility:
//   - init_done=0: only req[0] is eligible.
//   - init_done=1: req[0] wins if set; otherwise round-robin over 1..NUM_REQ-1 starting at the pointer.
//  Latency: req rises in IDLE -> grant and data at +1 -> en_write at +2.
//  Throughput: a locked burst reaches the next en_write 2 cycles after wr_done.
//  Boundary rules:
//   - wr_done in IDLE, ISSUE or ACK: ignored.
//   - req[owner] dropped mid-transaction: the word still completes and is acked; no lock continuation.
//   - req_data changes after grant: no effect until the next registration.
//   - init_done falls while a source >0 owns the bus: the current word completes; lock is then ignored and req[0] wins next.
//   - NUM_REQ=1: pointer logic degenerates; only index 0 is served.
//   - reset mid-transaction: immediate IDLE, en_write is never re-pulsed, the word is lost.
// CONFIGURATION
//  LCD_ARB_TIMEOUT_EN defined:
//   - a counter runs in WAIT
//   - at TIMEOUT_CYC cycles without wr_done: timeout_err sets (sticky until reset), no ack, grant clears, go to IDLE
//   - the pointer advances past the offender
//   - wr_done in the same cycle as expiry counts as success
//  Not defined:
//   - no counter; WAIT waits forever
//   - timeout_err tied to 0
// STRUCTURE
//  Shared package lcd_pkg:
//   - LCD_DATA_W = 9 and LCD_DC_BIT = 8
//   - arbiter state enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK}
//   - requester index constants REQ_INIT = 0, REQ_CHAR = 1, REQ_FILL = 2
//  Sub-module lcd_rr_pick: combinational; inputs are the eligible mask and the pointer, outputs are the one-hot winner and a valid flag.
// TESTING
//  1. Reset, then init_done=0; req=3'b110 plus req[0] with data 9'h011:
//     only source 0 is granted; en_write 2 cycles later with data 9'h011; ack[0] 1 cycle after wr_done.
//  2. init_done=1; req[1] and req[2] held for 4 words each, lock=0:
//     grant order 1,2,1,2,...; every ack is a single cycle.
//  3. lock[1]=1 for 3 words (9'h02A, 9'h100, 9'h1EF) while req[2] is pending:
//     all 3 words are served before grant[2]; a new en_write follows 2 cycles after each wr_done.
//  4. req[0] rises while source 2 is in WAIT:
//     source 2 completes and is acked; source 0 is granted next, ahead of the pointer.
//  5. Spurious wr_done in IDLE, then reset asserted in WAIT:
//     no ack or state change on the spurious pulse; after reset all outputs are 0 and the pointer is 1.
//  6. LCD_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, wr_done withheld:
//     timeout_err=1 on cycle 16 of WAIT; grant clears; no ack; the next requester is served normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD word format, arbiter state encoding and requester indices
package lcd_pkg;
   localparam int LCD_DATA_W = 9;
   localparam int LCD_DC_BIT = 8;
   localparam int REQ_INIT = 0;
   localparam int REQ_CHAR = 1;
   localparam int REQ_FILL = 2;
   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK} arb_state_t;
   // Round-robin successor over 1..n-1; index 0 never takes a turn
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 1 : idx + 1;
   endfunction
endpackage

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if: requester/serializer handshake bundle around the arbiter
interface lcd_write_arbiter_if #(parameter int NUM_REQ = 3, parameter int DATA_W = 9);
   logic init_done;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] lock;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] ack;
   logic [DATA_W-1:0] data;
   logic en_write;
   logic wr_done;
   logic busy;
   logic timeout_err;
   modport master (input init_done, req, lock, req_data, wr_done,
                   output grant, ack, data, en_write, busy, timeout_err);
   modport slave (output init_done, req, lock, req_data, wr_done,
                  input grant, ack, data, en_write, busy, timeout_err);
endinterface

// File: rtl/lcd_rr_pick.sv
// lcd_rr_pick: index 0 wins outright, else first set bit of 1..N-1 at or after ptr (wrapping)
module lcd_rr_pick #(parameter int N = 3, parameter int PW = 2) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic          valid
);
   logic [N-1:0] hi, lo;
   always_comb begin
      hi = '0;
      lo = '0;
      for (int i = N - 1; i >= 1; i--) begin
         if (mask[i]) begin
            lo = '0;
            lo[i] = 1'b1;
            if (i >= int'(ptr)) begin
               hi = '0;
               hi[i] = 1'b1;
            end
         end
      end
      win = mask[0] ? N'(1) : (|hi ? hi : lo);
      valid = |mask;
   end
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares one lcd_write serializer among requesters, with lock bursts.
// Optional LCD_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC cycles and raises sticky timeout_err.
module lcd_write_arbiter import lcd_pkg::*; #(
   parameter int NUM_REQ     = 3,
   parameter int DATA_W      = LCD_DATA_W,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic sys_clk_50MHz,
   input logic sys_rst_n,
   lcd_write_arbiter_if.master bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   arb_state_t state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, elig, win;
   logic [DATA_W-1:0] data_q, data_d, wdata, odata;
   logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
   logic en_q, en_d, win_vld, cont, expire;
   assign elig = bus.init_done ? bus.req : bus.req & NUM_REQ'(1 << REQ_INIT);
   assign cont = |(grant_q & bus.lock & bus.req) & (grant_q[REQ_INIT] | bus.init_done);
   lcd_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.mask(elig), .ptr(ptr_q), .win(win), .valid(win_vld));
   always_comb begin
      ptr_nxt = ptr_q;
      wdata = '0;
      odata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) wdata = bus.req_data[i*DATA_W +: DATA_W];
         if (grant_q[i]) begin
            odata = bus.req_data[i*DATA_W +: DATA_W];
            ptr_nxt = PW'(rr_next(i, NUM_REQ));
         end
      end
   end
   // A locked continuation fires en_write on leaving ACK, so ISSUE then stays quiet
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ack_d = '0;
      data_d = data_q;
      en_d = 1'b0;
      ptr_d = ptr_q;
      case (state_q)
         ARB_IDLE: if (win_vld) begin
            grant_d = win;
            data_d = wdata;
            state_d = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            en_d = ~en_q;
            state_d = ARB_WAIT;
         end
         ARB_WAIT: if (bus.wr_done) begin
            ack_d = grant_q;
            state_d = ARB_ACK;
         end else if (expire) begin
            grant_d = '0;
            ptr_d = ptr_nxt;
            state_d = ARB_IDLE;
         end
         ARB_ACK: if (cont) begin
            data_d = odata;
            en_d = 1'b1;
            state_d = ARB_ISSUE;
         end else begin
            grant_d = '0;
            ptr_d = ptr_nxt;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end
   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ack_q <= '0;
         data_q <= '0;
         en_q <= 1'b0;
         ptr_q <= PW'(1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q <= ack_d;
         data_q <= data_d;
         en_q <= en_d;
         ptr_q <= ptr_d;
      end
`ifdef LCD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic terr_q, terr_d;
   assign expire = cnt_q == CW'(TIMEOUT_CYC - 1);
   always_comb begin
      cnt_d = state_q == ARB_WAIT ? cnt_q + 1'b1 : '0;
      terr_d = terr_q | (state_q == ARB_WAIT & ~bus.wr_done & expire);
   end
   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n)
      if (!sys_rst_n) begin
         cnt_q <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         terr_q <= terr_d;
      end
   assign bus.timeout_err = terr_q;
`else
   assign expire = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif
   assign bus.grant = grant_q;
   assign bus.ack = ack_q;
   assign bus.data = data_q;
   assign bus.en_write = en_q;
   assign bus.busy = state_q != ARB_IDLE;
endmodule
